// File: rtl/vmem_arb_pkg.sv
// vmem_arb_pkg: shared state encoding, requester indices and default widths for the vector port arbiter
package vmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_FIR = 1;
  localparam int AW_DEF = 14;
  localparam int DW_DEF = 128;
endpackage

// File: rtl/vmem_arb_stats.sv
// vmem_arb_stats: saturating per-requester grant and wait counters (present only with VMEM_ARB_STATS_EN)
module vmem_arb_stats
  import vmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  gnt,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [31:0] wait_cnt0,
  output logic [31:0] wait_cnt1
);
  logic [1:0] waiting;
  assign waiting = req & ~gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt0  <= '0;
      wait_cnt1  <= '0;
    end else begin
      grant_cnt0 <= grant_cnt0 + 32'(gnt[REQ_CPU] & ~&grant_cnt0);
      grant_cnt1 <= grant_cnt1 + 32'(gnt[REQ_FIR] & ~&grant_cnt1);
      wait_cnt0  <= wait_cnt0 + 32'(waiting[REQ_CPU] & ~&wait_cnt0);
      wait_cnt1  <= wait_cnt1 + 32'(waiting[REQ_FIR] & ~&wait_cnt1);
    end
endmodule

// File: rtl/vmem_port_arbiter.sv
// vmem_port_arbiter: round-robin arbiter with burst lock sharing the 128-bit vector memory port.
// Optional statistics counters are built when VMEM_ARB_STATS_EN is defined.
module vmem_port_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    lock,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef VMEM_ARB_STATS_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   wait_cnt0,
  output logic [31:0]   wait_cnt1
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
  arb_state_t state, state_n;
  logic [CW-1:0] burst_cnt, burst_n;
  logic last_owner, o;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  assign o = (state == OWN1);
  // gnt is forced low while reset is high so an in-flight beat dies immediately
  always_comb begin
    gnt = 2'b00;
    state_n = state;
    burst_n = burst_cnt;
    if (state == IDLE) begin
      gnt = (req == 2'b11) ? (last_owner ? 2'b01 : 2'b10) : req;
      state_n = (gnt[0] & lock[0]) ? OWN0 : (gnt[1] & lock[1]) ? OWN1 : IDLE;
      burst_n = '0;
    end else begin
      gnt = o ? {req[1], 1'b0} : {1'b0, req[0]};
      if (!req[o] || !lock[o] || (burst_cnt == CAP && req[~o]))
        state_n = IDLE;
      else
        burst_n = (burst_cnt == CAP) ? burst_cnt : burst_cnt + 1'b1;
    end
    if (reset) gnt = 2'b00;
  end
  assign mem_addr  = gnt[REQ_CPU] ? addr0  : gnt[REQ_FIR] ? addr1  : addr_q;
  assign mem_wdata = gnt[REQ_CPU] ? wdata0 : gnt[REQ_FIR] ? wdata1 : wdata_q;
  assign mem_we    = |(gnt & we);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rvalid     <= 2'b00;
      rdata      <= '0;
    end else begin
      state     <= state_n;
      burst_cnt <= burst_n;
      if (|gnt) last_owner <= gnt[REQ_FIR];
      addr_q    <= mem_addr;
      wdata_q   <= mem_wdata;
      rvalid    <= gnt & ~we;
      rdata     <= mem_rdata;
    end
`ifdef VMEM_ARB_STATS_EN
  vmem_arb_stats u_stats (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1)
  );
`endif
endmodule
